// File: rtl/acc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// acc_ctrl_pkg
// Shared definitions for the accumulator-datapath controller:
//   - opcode values (IR[7:4])
//   - datapath select encodings (MUX_*, ALU_*, SH_*)
//   - controller state enum (adds ST_WAIT when ACC_CTRL_SINGLE_STEP_EN is defined)
//   - control-word struct produced by acc_ctrl_decode
//   - is_two_byte() helper identifying opcodes that carry an operand byte
// Optional feature macro: ACC_CTRL_SINGLE_STEP_EN
// -----------------------------------------------------------------------------
package acc_ctrl_pkg;

  // Opcodes (upper nibble of the instruction byte)
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_LDI = 4'h2;
  localparam logic [3:0] OP_JMP = 4'h3;
  localparam logic [3:0] OP_JZ  = 4'h4;
  localparam logic [3:0] OP_JP  = 4'h5;
  localparam logic [3:0] OP_ADD = 4'h6;
  localparam logic [3:0] OP_SUB = 4'h7;
  localparam logic [3:0] OP_AND = 4'h8;
  localparam logic [3:0] OP_OR  = 4'h9;
  localparam logic [3:0] OP_NOT = 4'hA;
  localparam logic [3:0] OP_INC = 4'hB;
  localparam logic [3:0] OP_DEC = 4'hC;
  localparam logic [3:0] OP_SHF = 4'hD;
  localparam logic [3:0] OP_IN  = 4'hE;
  localparam logic [3:0] OP_SYS = 4'hF;  // IR[3]=0 OUT, IR[3]=1 HALT

  // Datapath mux select
  localparam logic [1:0] MUX_SHIFT = 2'b00;
  localparam logic [1:0] MUX_RF    = 2'b01;
  localparam logic [1:0] MUX_IN    = 2'b10;
  localparam logic [1:0] MUX_IMM   = 2'b11;

  // ALU operation select
  localparam logic [2:0] ALU_PASSA = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_NOT   = 3'b101;
  localparam logic [2:0] ALU_INC   = 3'b110;
  localparam logic [2:0] ALU_DEC   = 3'b111;

  // Shifter select
  localparam logic [1:0] SH_PASS = 2'b00;
  localparam logic [1:0] SH_SHL  = 2'b01;
  localparam logic [1:0] SH_SHR  = 2'b10;
  localparam logic [1:0] SH_ROR  = 2'b11;

`ifdef ACC_CTRL_SINGLE_STEP_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_OPND,
    ST_EXEC,
    ST_HALT,
    ST_WAIT
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_OPND,
    ST_EXEC,
    ST_HALT
  } state_t;
`endif

  // Branch condition carried by the control word; resolved by the FSM in EXEC
  typedef enum logic [1:0] {
    BR_NONE,
    BR_ALWAYS,
    BR_ZERO,
    BR_POS
  } branch_t;

  typedef struct packed {
    logic [1:0] muxsel;
    logic       accwr;
    logic [2:0] rfaddr;
    logic       rfwr;
    logic [2:0] alusel;
    logic [1:0] shiftsel;
    logic       outen;
    branch_t    branch;
    logic       halt;
  } ctrl_word_t;

  // All strobes low, selects at passA / pass / shifter
  localparam ctrl_word_t CTRL_NOP = '0;

  // Opcodes LDI, JMP, JZ, JP are followed by an operand byte
  function automatic logic is_two_byte(input logic [3:0] op);
    return (op >= OP_LDI) && (op <= OP_JP);
  endfunction

endpackage

// File: rtl/acc_ctrl_decode.sv
// -----------------------------------------------------------------------------
// acc_ctrl_decode
// Combinational instruction decoder. Turns the latched instruction register
// into the datapath control word; the word is forced to CTRL_NOP unless the
// controller is in EXEC. Also classifies the byte arriving from program
// memory as one- or two-byte so the FSM can decide during DECODE.
// Ports:
//   ir        in  DATA_W  latched instruction register
//   exec      in  1       controller is in EXEC
//   peek_op   in  4       opcode nibble of the byte currently on pm_data
//   ctrl      out struct  control word (strobes, selects, branch kind, halt)
//   two_byte  out 1       peek_op carries an operand byte
// -----------------------------------------------------------------------------
module acc_ctrl_decode
  import acc_ctrl_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] ir,
  input  logic              exec,
  input  logic [3:0]        peek_op,
  output ctrl_word_t        ctrl,
  output logic              two_byte
);

  logic [3:0] op;
  logic [2:0] r;

  assign op       = ir[DATA_W-1 -: 4];
  assign r        = ir[2:0];
  assign two_byte = is_two_byte(peek_op);

  always_comb begin
    ctrl = CTRL_NOP;
    if (exec) begin
      case (op)
        OP_LDA: begin
          ctrl.muxsel = MUX_RF;
          ctrl.accwr  = 1'b1;
          ctrl.rfaddr = r;
        end
        OP_STA: begin
          ctrl.rfwr   = 1'b1;
          ctrl.rfaddr = r;
        end
        OP_LDI: begin
          ctrl.muxsel = MUX_IMM;
          ctrl.accwr  = 1'b1;
        end
        // Jumps leave the datapath on ACC->ALU passA->shifter pass so the
        // zero/positive flags describe ACC during this cycle.
        OP_JMP: ctrl.branch = BR_ALWAYS;
        OP_JZ:  ctrl.branch = BR_ZERO;
        OP_JP:  ctrl.branch = BR_POS;
        OP_ADD: begin
          ctrl.alusel = ALU_ADD;
          ctrl.accwr  = 1'b1;
          ctrl.rfaddr = r;
        end
        OP_SUB: begin
          ctrl.alusel = ALU_SUB;
          ctrl.accwr  = 1'b1;
          ctrl.rfaddr = r;
        end
        OP_AND: begin
          ctrl.alusel = ALU_AND;
          ctrl.accwr  = 1'b1;
          ctrl.rfaddr = r;
        end
        OP_OR: begin
          ctrl.alusel = ALU_OR;
          ctrl.accwr  = 1'b1;
          ctrl.rfaddr = r;
        end
        OP_NOT: begin
          ctrl.alusel = ALU_NOT;
          ctrl.accwr  = 1'b1;
        end
        OP_INC: begin
          ctrl.alusel = ALU_INC;
          ctrl.accwr  = 1'b1;
        end
        OP_DEC: begin
          ctrl.alusel = ALU_DEC;
          ctrl.accwr  = 1'b1;
        end
        OP_SHF: begin
          ctrl.shiftsel = ir[1:0];
          ctrl.accwr    = 1'b1;
        end
        OP_IN: begin
          ctrl.muxsel = MUX_IN;
          ctrl.accwr  = 1'b1;
        end
        OP_SYS: begin
          if (ir[3]) ctrl.halt  = 1'b1;
          else       ctrl.outen = 1'b1;
        end
        default: ctrl = CTRL_NOP;
      endcase
    end
  end

endmodule

// File: rtl/acc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// acc_ctrl_fsm
// Multi-cycle controller for the 8-bit accumulator datapath. Fetches from a
// synchronous program ROM (data valid one cycle after pm_addr), decodes,
// and drives the datapath strobes for one EXEC cycle per instruction.
// One-byte instructions: FETCH, DECODE, EXEC. Two-byte: FETCH, DECODE,
// OPND, EXEC. HALT is terminal until rst_acc.
// Optional feature macro: ACC_CTRL_SINGLE_STEP_EN -- adds input step and a
// WAIT state after each executed instruction; each rising edge of step
// releases exactly one instruction.
// Ports:
//   clk_acc   in  1       clock, rising edge
//   rst_acc   in  1       asynchronous active-high reset
//   start     in  1       leave IDLE, execute from PC=0
//   step      in  1       single-step advance (only with the macro)
//   pm_addr   out PC_W    program ROM address
//   pm_data   in  DATA_W  program ROM read data
//   imm       out DATA_W  operand register to datapath
//   muxsel    out 2       datapath mux select
//   accwr     out 1       accumulator write
//   rfaddr    out 3       register file address
//   rfwr      out 1       register file write
//   alusel    out 3       ALU operation
//   shiftsel  out 2       shifter operation
//   outen     out 1       output-port enable
//   zero      in  1       datapath zero flag
//   positive  in  1       datapath positive flag
//   halted    out 1       HALT has executed
//   pc        out PC_W    current program counter
// -----------------------------------------------------------------------------
module acc_ctrl_fsm
  import acc_ctrl_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk_acc,
  input  logic              rst_acc,
  input  logic              start,
`ifdef ACC_CTRL_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic [PC_W-1:0]   pm_addr,
  input  logic [DATA_W-1:0] pm_data,
  output logic [DATA_W-1:0] imm,
  output logic [1:0]        muxsel,
  output logic              accwr,
  output logic [2:0]        rfaddr,
  output logic              rfwr,
  output logic [2:0]        alusel,
  output logic [1:0]        shiftsel,
  output logic              outen,
  input  logic              zero,
  input  logic              positive,
  output logic              halted,
  output logic [PC_W-1:0]   pc
);

  state_t              state_reg;
  logic [PC_W-1:0]     pc_reg;
  logic [DATA_W-1:0]   ir_reg;
  logic [DATA_W-1:0]   opr_reg;
`ifdef ACC_CTRL_SINGLE_STEP_EN
  logic                step_d_reg;
`endif

  ctrl_word_t          ctrl;
  logic                two_byte;
  logic                branch_taken;

  acc_ctrl_decode #(
    .DATA_W (DATA_W)
  ) u_decode (
    .ir       (ir_reg),
    .exec     (state_reg == ST_EXEC),
    .peek_op  (pm_data[DATA_W-1 -: 4]),
    .ctrl     (ctrl),
    .two_byte (two_byte)
  );

  always_comb begin
    branch_taken = 1'b0;
    case (ctrl.branch)
      BR_ALWAYS: branch_taken = 1'b1;
      BR_ZERO:   branch_taken = zero;
      BR_POS:    branch_taken = positive;
      default:   branch_taken = 1'b0;
    endcase
  end

  // The ROM is addressed straight from PC: in FETCH this is the opcode
  // address, and in DECODE PC has already advanced to the operand address.
  always_ff @(posedge clk_acc or posedge rst_acc) begin
    if (rst_acc) begin
      state_reg  <= ST_IDLE;
      pc_reg     <= '0;
      ir_reg     <= '0;
      opr_reg    <= '0;
`ifdef ACC_CTRL_SINGLE_STEP_EN
      step_d_reg <= 1'b0;
`endif
    end else begin
`ifdef ACC_CTRL_SINGLE_STEP_EN
      step_d_reg <= step;
`endif
      case (state_reg)
        ST_IDLE: begin
          if (start) state_reg <= ST_FETCH;
        end
        ST_FETCH: begin
          pc_reg    <= pc_reg + PC_W'(1);
          state_reg <= ST_DECODE;
        end
        ST_DECODE: begin
          ir_reg <= pm_data;
          if (two_byte) begin
            pc_reg    <= pc_reg + PC_W'(1);
            state_reg <= ST_OPND;
          end else begin
            state_reg <= ST_EXEC;
          end
        end
        ST_OPND: begin
          opr_reg   <= pm_data;
          state_reg <= ST_EXEC;
        end
        ST_EXEC: begin
          // Not-taken jumps keep PC, which already points past the operand.
          if (branch_taken) pc_reg <= PC_W'(opr_reg);
          if (ctrl.halt) begin
            state_reg <= ST_HALT;
          end else begin
`ifdef ACC_CTRL_SINGLE_STEP_EN
            state_reg <= ST_WAIT;
`else
            state_reg <= ST_FETCH;
`endif
          end
        end
        ST_HALT: begin
          state_reg <= ST_HALT;
        end
`ifdef ACC_CTRL_SINGLE_STEP_EN
        ST_WAIT: begin
          // Only a 0->1 transition releases the next instruction, so a
          // held-high step does not free-run the program.
          if (step && !step_d_reg) state_reg <= ST_FETCH;
        end
`endif
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign pm_addr  = pc_reg;
  assign pc       = pc_reg;
  assign imm      = opr_reg;
  assign halted   = (state_reg == ST_HALT);
  assign muxsel   = ctrl.muxsel;
  assign accwr    = ctrl.accwr;
  assign rfaddr   = ctrl.rfaddr;
  assign rfwr     = ctrl.rfwr;
  assign alusel   = ctrl.alusel;
  assign shiftsel = ctrl.shiftsel;
  assign outen    = ctrl.outen;

endmodule
